// File: rtl/bs_enc_ctrl_if.sv
// Request, bit-source and encoder-control signals of the backscatter encoder sequencer.
// Bit source handshake: a bit moves on a clock edge where bit_ready && bit_valid; bit_ready never looks at bit_valid.
interface bs_enc_ctrl_if;
    logic       start;
    logic [1:0] m_sel;
    logic       trext;
    logic [7:0] tx_len;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       en_fm0;
    logic       st_enc;
    logic       send_data;
    logic       fg_complete;
    logic       busy;
    logic       done;
    logic       underrun;

    modport slave (
        input  start, m_sel, trext, tx_len, bit_in, bit_valid,
        output bit_ready, en_fm0, st_enc, send_data, fg_complete, busy, done, underrun
    );

    modport master (
        output start, m_sel, trext, tx_len, bit_in, bit_valid,
        input  bit_ready, en_fm0, st_enc, send_data, fg_complete, busy, done, underrun
    );
endinterface

// File: rtl/bs_enc_ctrl.sv
// Backscatter encoder sequencer: paces preamble, data and tail symbols in clk_blf cycles
// and feeds reply bits to the FM0/Miller encoder pair. Every output is a flop.
module bs_enc_ctrl (
    input  logic               clk_blf,
    input  logic               rst_for_new_package,
    bs_enc_ctrl_if.slave       bus,
    output logic [2:0]         dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_TAIL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sym_q, sym_d;
    logic [4:0] ph_q, ph_d;
    logic [7:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] m_q, m_d;
    logic       trext_q, trext_d;
    logic [7:0] len_q, len_d;
    logic       und_q, und_d;
    logic       sd_q, sd_d;
    logic       rdy_q, rdy_d;
    logic       fg_q, fg_d;
    logic       st_q, st_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       en_q, en_d;
    logic       sym_last;
    logic [2:0] sym_wrap;
    logic       miss;

    function automatic logic [2:0] sym_max(input logic [1:0] m);
        case (m)
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [4:0] pre_last(input logic [1:0] m, input logic t);
        if (m == 2'b00) return t ? 5'd17 : 5'd5;
        return t ? 5'd21 : 5'd9;
    endfunction

    assign sym_last = (sym_q == sym_max(m_q));
    assign sym_wrap = sym_last ? 3'd0 : sym_q + 3'd1;
    assign miss     = rdy_q & ~bus.bit_valid;

    always_ff @(posedge clk_blf) begin
        if (!rst_for_new_package) begin
            state_q   <= S_IDLE;
            sym_q     <= 3'd0;
            ph_q      <= 5'd0;
            bit_cnt_q <= 8'd0;
            m_q       <= 2'b00;
            trext_q   <= 1'b0;
            len_q     <= 8'd0;
            und_q     <= 1'b0;
            sd_q      <= 1'b0;
            rdy_q     <= 1'b0;
            fg_q      <= 1'b0;
            st_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            sym_q     <= sym_d;
            ph_q      <= ph_d;
            bit_cnt_q <= bit_cnt_d;
            m_q       <= m_d;
            trext_q   <= trext_d;
            len_q     <= len_d;
            und_q     <= und_d;
            sd_q      <= sd_d;
            rdy_q     <= rdy_d;
            fg_q      <= fg_d;
            st_q      <= st_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en_q      <= en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sym_d     = sym_q;
        ph_d      = ph_q;
        bit_cnt_d = bit_cnt_q;
        m_d       = m_q;
        trext_d   = trext_q;
        len_d     = len_q;
        und_d     = und_q;
        sd_d      = sd_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d     = bus.m_sel;
                    trext_d = bus.trext;
                    len_d   = bus.tx_len;
                    und_d   = 1'b0;
                    sym_d   = 3'd0;
                    ph_d    = 5'd0;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                sym_d = sym_wrap;
                if (sym_last) begin
                    if (ph_q == pre_last(m_q, trext_q)) begin
                        ph_d = 5'd0;
                        if (miss) begin
                            und_d   = 1'b1;
                            state_d = S_TAIL;
                        end else if (len_q == 8'd0) begin
                            state_d = S_TAIL;
                        end else begin
                            bit_cnt_d = len_q;
                            sd_d      = bus.bit_in;
                            state_d   = S_DATA;
                        end
                    end else begin
                        ph_d = ph_q + 5'd1;
                    end
                end
            end
            S_DATA: begin
                sym_d = sym_wrap;
                if (sym_last) begin
                    // bit_cnt holds the bits still to send, including the current one.
                    if (bit_cnt_q <= 8'd1) begin
                        bit_cnt_d = 8'd0;
                        ph_d      = 5'd0;
                        state_d   = S_TAIL;
                    end else if (miss) begin
                        und_d     = 1'b1;
                        bit_cnt_d = 8'd0;
                        ph_d      = 5'd0;
                        state_d   = S_TAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 8'd1;
                        sd_d      = bus.bit_in;
                    end
                end
            end
            S_TAIL: begin
                sym_d = sym_wrap;
                if (sym_last) begin
                    if (ph_q == 5'd2) begin
                        ph_d    = 5'd0;
                        state_d = S_DONE;
                    end else begin
                        ph_d = ph_q + 5'd1;
                    end
                end
            end
            default: begin
                sym_d   = 3'd0;
                ph_d    = 5'd0;
                state_d = S_IDLE;
            end
        endcase

        // The dummy 1 occupies the first tail symbol; outside DATA/TAIL the level is 0.
        if (state_d == S_TAIL)      sd_d = (ph_d == 5'd0);
        else if (state_d != S_DATA) sd_d = 1'b0;

        st_d   = (state_d == S_PRE) || (state_d == S_DATA) || (state_d == S_TAIL);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        en_d   = (m_d == 2'b00);
        fg_d   = (state_d == S_TAIL) && (sym_d == 3'd0);
        rdy_d  = (sym_d == sym_max(m_d)) &&
                 (((state_d == S_PRE) && (ph_d == pre_last(m_d, trext_d)) && (len_d != 8'd0)) ||
                  ((state_d == S_DATA) && (bit_cnt_d > 8'd1)));
    end

    assign bus.bit_ready   = rdy_q;
    assign bus.en_fm0      = en_q;
    assign bus.st_enc      = st_q;
    assign bus.send_data   = sd_q;
    assign bus.fg_complete = fg_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.underrun    = und_q;
    assign dbg_state       = state_q;
endmodule
